parking_meter_core: RTL and testbench
=====================================

# parking_meter_core

Parking-meter controller: accumulates paid time from four coin buttons, counts it down once per second, and drives a 4-digit multiplexed 7-segment display. Display is steady at 180 s or more, blinks on even/odd seconds below 180 s, and blinks at 1 Hz when time is exhausted. Sits directly under the board top level; debounced button pulses in, segment/anode pins out.

## Interface
- `TICKS_PER_SEC`, default 100: `clk` cycles per second.
- `MAX_TIME`, default 9999: saturation value in seconds.
- `LOW_THRESH`, default 180: seconds below which the display blinks.
- `clk` input, 1 bit: single system clock, 100 Hz nominal.
- `rst` input, 1 bit: reset; asynchronous, active-low. Clears time to 0.
- `add1` input, 1 bit: add 60 s, on rising edge.
- `add2` input, 1 bit: add 120 s, on rising edge.
- `add3` input, 1 bit: add 180 s, on rising edge.
- `add4` input, 1 bit: add 300 s, on rising edge.
- `rst1` input, 1 bit: load 15 s, on rising edge.
- `rst2` input, 1 bit: load 150 s, on rising edge.
- `led_seg` output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
- `a1` to `a4` outputs, 1 bit each: digit anodes, active-low. `a1` is thousands, `a4` is ones.
- `val1` to `val4` outputs, 4 bits each: BCD of remaining time. `val1` is thousands, `val4` is ones.

## Operation
- Edge detection:
  - Every button input is registered, and a one-cycle event fires when it is high now and was low in the previous cycle.
  - Holding a button produces exactly one event.
- Load priority in a single cycle: `rst1` > `rst2` > adds.
- Adds in the same cycle are summed.
- Sum saturates: time = min(time + sum, `MAX_TIME`).
- `rst1`/`rst2` overwrite time and clear the second counter.
- Second counter runs 0..`TICKS_PER_SEC`-1. At terminal count, time decrements by 1 if nonzero, otherwise stays 0.
- A load or add in the same cycle as a decrement: the load or add wins and the decrement is dropped.
- Time register is 14 bits. BCD is derived combinationally by division/modulo or double-dabble.
- States are derived from time:
  - ZERO: time = 0. Display "0000" when second counter < `TICKS_PER_SEC`/2, blank otherwise.
  - LOW: 0 < time < `LOW_THRESH`. Display on when time is even, blank when time is odd.
  - HIGH: time ≥ `LOW_THRESH`. Display always on.
- Multiplexing:
  - A 2-bit digit pointer advances every `clk` cycle, a1→a2→a3→a4→a1.
  - Exactly one anode is low when displaying. All anodes are high and `led_seg` = 7'h7F when blank.
  - Leading zeros are shown.
- Segment codes are active-low. '0' is 7'b1000000 and '8' is 7'b0000000.

## Timing
- Reset values:
  - time 0, second counter 0, digit pointer 0.
  - Edge registers 0.
  - `val1`–`val4` = 0.
  - `a1` = 0, `a2`–`a4` = 1, `led_seg` = 7'b1000000.
  - Reset puts the block in ZERO, display-on phase.
- A button high at clock edge N updates time at edge N; `val*` reflects it after edge N.
- First decrement after a `rst1`/`rst2` load occurs exactly `TICKS_PER_SEC` cycles later.
- After an add, the next decrement follows the free-running second counter, which is not cleared.
- Reset asserted mid-countdown clears immediately, asynchronously. Countdown resumes from 0 on the next second boundary.

## Configuration
- `PARKING_METER_DEBUG_EN` defined:
  - Adds outputs `time_left[13:0]` (binary time), `count_main[6:0]` (second counter) and `current_state[1:0]`.
  - `current_state` encoding: ZERO = 0, LOW = 1, HIGH = 2.
- Undefined: those ports and their logic are absent. Functional behaviour is identical either way.

## Structure
- Shared package `parking_meter_pkg` holds:
  - the state enum;
  - the add/load constants 60, 120, 180, 300, 15, 150;
  - the 7-segment decode function.
- One sub-module `bcd_seg_mux`: takes 4 BCD digits plus a blank flag, and outputs the anode rotation and `led_seg`.

## Test plan
- Reset, then `add1` → `val*` = 0060 next cycle. After 100 cycles, 0059. The display blanks during 59 and shows during 58.
- `add3` with time 120 → 0300 in HIGH state. Display steady, with anodes rotating one per cycle.
- `rst1` mid-countdown at 0400 → 0015, second counter cleared. After 100 cycles, 0014. After 1500 cycles, 0000.
- In ZERO: 50 cycles showing "0000" then 50 cycles all anodes high, repeating.
- 37 `add4` pulses from 0 → 9999, saturated. Then one decrement per 100 cycles.
- Boundary: 0180 is steady; after the next tick, 0179 is blank. `rst` asserted mid-countdown → 0000 immediately.

Source files
------------

// File: rtl/parking_meter_pkg.sv
// Shared types and constants for the parking meter: display state, coin/load
// amounts and the active-low 7-segment decoder.
package parking_meter_pkg;

  typedef enum logic [1:0] {
    ST_ZERO = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } meter_state_e;

  localparam int TIME_W = 14;

  localparam int unsigned ADD1_SEC  = 60;
  localparam int unsigned ADD2_SEC  = 120;
  localparam int unsigned ADD3_SEC  = 180;
  localparam int unsigned ADD4_SEC  = 300;
  localparam int unsigned LOAD1_SEC = 15;
  localparam int unsigned LOAD2_SEC = 150;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0; non-BCD codes blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/parking_meter_if.sv
// Board-facing signal bundle of the parking meter: button pulses in,
// display pins and BCD readout out.
interface parking_meter_if;
  // No valid/ready here: buttons are debounced levels sampled every clock and
  // acted on at their rising edge; outputs are continuously valid, no backpressure.
  logic       add1;
  logic       add2;
  logic       add3;
  logic       add4;
  logic       rst1;
  logic       rst2;
  logic [6:0] led_seg;
  logic       a1;
  logic       a2;
  logic       a3;
  logic       a4;
  logic [3:0] val1;
  logic [3:0] val2;
  logic [3:0] val3;
  logic [3:0] val4;

  modport master (
    output add1, add2, add3, add4, rst1, rst2,
    input  led_seg, a1, a2, a3, a4, val1, val2, val3, val4
  );

  modport slave (
    input  add1, add2, add3, add4, rst1, rst2,
    output led_seg, a1, a2, a3, a4, val1, val2, val3, val4
  );
endinterface

// File: rtl/parking_meter_bcd_seg_mux.sv
// Four-digit multiplexer: rotates one active-low anode per clock (a1 first)
// and drives the matching digit's segments, or blanks everything.
module bcd_seg_mux
  import parking_meter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic       blank,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic       a4,
  output logic [6:0] led_seg
);

  logic [1:0] digit_ptr;
  logic [3:0] digit;
  logic [3:0] anode_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) digit_ptr <= 2'd0;
    else      digit_ptr <= digit_ptr + 2'd1;
  end

  always_comb begin
    case (digit_ptr)
      2'd0:    digit = d1;
      2'd1:    digit = d2;
      2'd2:    digit = d3;
      default: digit = d4;
    endcase
  end

  // anode_n[3] is a1 (thousands), anode_n[0] is a4 (ones).
  always_comb begin
    anode_n = 4'b1111;
    led_seg = SEG_BLANK;
    if (!blank) begin
      anode_n = ~(4'b1000 >> digit_ptr);
      led_seg = seg_decode(digit);
    end
  end

  assign a1 = anode_n[3];
  assign a2 = anode_n[2];
  assign a3 = anode_n[1];
  assign a4 = anode_n[0];

endmodule

// File: rtl/parking_meter_core.sv
// Parking meter controller: coin adds, preset loads, 1 s countdown and blinking
// multiplexed display. Optional debug ports under PARKING_METER_DEBUG_EN.
module parking_meter_core
  import parking_meter_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int MAX_TIME      = 9999,
  parameter int LOW_THRESH    = 180
) (
  input  logic            clk,
  input  logic            rst,
  parking_meter_if.slave  bus
`ifdef PARKING_METER_DEBUG_EN
  ,
  output logic [13:0]     time_left,
  output logic [6:0]      count_main,
  output logic [1:0]      current_state
`endif
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [5:0]        btn;
  logic [5:0]        btn_q;
  logic [5:0]        btn_evt;
  logic [10:0]       add_sum;
  logic [TIME_W:0]   time_sum;
  logic [TIME_W-1:0] time_q;
  logic [TIME_W-1:0] time_d;
  logic [CNT_W-1:0]  sec_cnt_q;
  logic [CNT_W-1:0]  sec_cnt_d;
  logic              sec_tick;
  meter_state_e      state;
  logic              blank;
  logic [3:0]        v1, v2, v3, v4;
  logic [6:0]        seg_w;
  logic              a1_w, a2_w, a3_w, a4_w;

  // Bit order {rst1, rst2, add4, add3, add2, add1}.
  assign btn     = {bus.rst1, bus.rst2, bus.add4, bus.add3, bus.add2, bus.add1};
  assign btn_evt = btn & ~btn_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_q <= '0;
    else      btn_q <= btn;
  end

  always_comb begin
    add_sum = '0;
    if (btn_evt[0]) add_sum = add_sum + 11'(ADD1_SEC);
    if (btn_evt[1]) add_sum = add_sum + 11'(ADD2_SEC);
    if (btn_evt[2]) add_sum = add_sum + 11'(ADD3_SEC);
    if (btn_evt[3]) add_sum = add_sum + 11'(ADD4_SEC);
  end

  assign time_sum = {1'b0, time_q} + (TIME_W + 1)'(add_sum);
  assign sec_tick = (sec_cnt_q == CNT_W'(TICKS_PER_SEC - 1));

  // Loads beat adds, and any load or add swallows a coincident decrement.
  always_comb begin
    time_d    = time_q;
    sec_cnt_d = sec_tick ? '0 : sec_cnt_q + 1'b1;
    if (btn_evt[5]) begin
      time_d    = TIME_W'(LOAD1_SEC);
      sec_cnt_d = '0;
    end else if (btn_evt[4]) begin
      time_d    = TIME_W'(LOAD2_SEC);
      sec_cnt_d = '0;
    end else if (|btn_evt[3:0]) begin
      if (time_sum > (TIME_W + 1)'(MAX_TIME)) time_d = TIME_W'(MAX_TIME);
      else                                     time_d = time_sum[TIME_W-1:0];
    end else if (sec_tick && (time_q != '0)) begin
      time_d = time_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_q    <= '0;
      sec_cnt_q <= '0;
    end else begin
      time_q    <= time_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

  always_comb begin
    int unsigned t;
    t  = 32'(time_q);
    v1 = 4'((t / 1000) % 10);
    v2 = 4'((t / 100) % 10);
    v3 = 4'((t / 10) % 10);
    v4 = 4'(t % 10);
  end

  always_comb begin
    if (time_q == '0)                        state = ST_ZERO;
    else if (time_q < TIME_W'(LOW_THRESH))   state = ST_LOW;
    else                                     state = ST_HIGH;
  end

  // ZERO flashes on the half-second phase; LOW shows on even seconds only.
  always_comb begin
    case (state)
      ST_ZERO: blank = (sec_cnt_q >= CNT_W'(TICKS_PER_SEC / 2));
      ST_LOW:  blank = time_q[0];
      default: blank = 1'b0;
    endcase
  end

  bcd_seg_mux u_mux (
    .clk     (clk),
    .rst     (rst),
    .d1      (v1),
    .d2      (v2),
    .d3      (v3),
    .d4      (v4),
    .blank   (blank),
    .a1      (a1_w),
    .a2      (a2_w),
    .a3      (a3_w),
    .a4      (a4_w),
    .led_seg (seg_w)
  );

  assign bus.led_seg = seg_w;
  assign bus.a1      = a1_w;
  assign bus.a2      = a2_w;
  assign bus.a3      = a3_w;
  assign bus.a4      = a4_w;
  assign bus.val1    = v1;
  assign bus.val2    = v2;
  assign bus.val3    = v3;
  assign bus.val4    = v4;

`ifdef PARKING_METER_DEBUG_EN
  assign time_left     = time_q;
  assign count_main    = 7'(sec_cnt_q);
  assign current_state = state;
`endif

endmodule

// File: tb/tb_parking_meter_core.sv
// Directed bench for parking_meter_core: countdown timing, load priority,
// blink phases, anode rotation and saturation with hand-computed expectations.
module tb_parking_meter_core;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   e = 0; // clock edges since the last reset release

  always #5 clk = ~clk;

  parking_meter_if pm_if ();

  parking_meter_core dut (
    .clk (clk),
    .rst (rst),
    .bus (pm_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic goto_edge(input int target);
    tick(target - e);
  endtask

  // m = {rst1, rst2, add4, add3, add2, add1}
  task automatic set_btn(input logic [5:0] m);
    pm_if.rst1 = m[5];
    pm_if.rst2 = m[4];
    pm_if.add4 = m[3];
    pm_if.add3 = m[2];
    pm_if.add2 = m[1];
    pm_if.add1 = m[0];
  endtask

  task automatic press(input logic [5:0] m);
    set_btn(m);
    tick(1);
    set_btn(6'b0);
  endtask

  task automatic check_val(input string tag, input logic [15:0] exp);
    check_eq(tag, {pm_if.val1, pm_if.val2, pm_if.val3, pm_if.val4}, exp);
  endtask

  task automatic check_disp(input string tag, input logic [3:0] an, input logic [6:0] seg);
    check_eq({tag, "_an"}, {pm_if.a1, pm_if.a2, pm_if.a3, pm_if.a4}, an);
    check_eq({tag, "_seg"}, pm_if.led_seg, seg);
  endtask

  task automatic async_reset();
    rst = 1'b0;
    #2;
    check_val("async_rst_val", 16'h0000);
    check_disp("async_rst_disp", 4'b0111, 7'b1000000);
    rst = 1'b1;
    e = 0;
  endtask

  initial begin
    rst = 1'b0;
    set_btn(6'b0);
    #23;
    check_val("reset_val", 16'h0000);
    check_disp("reset_disp", 4'b0111, 7'b1000000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    e = 0;

    // add1 then countdown; counter phase runs from reset release
    press(6'b000001);                        // E=1
    check_val("add1", 16'h0060);
    goto_edge(99);
    check_val("pre_tick", 16'h0060);
    goto_edge(100);
    check_val("tick_59", 16'h0059);
    check_disp("odd_blank", 4'b1111, 7'h7F);
    goto_edge(200);
    check_val("tick_58", 16'h0058);
    check_disp("even_on", 4'b0111, 7'b1000000);

    // load priority over adds, load clears the second counter
    press(6'b100010);                        // E=201 rst1+add2
    check_val("rst1_wins", 16'h0015);
    press(6'b011000);                        // E=202 rst2+add4
    check_val("rst2_wins", 16'h0150);
    goto_edge(301);
    check_val("load_pre", 16'h0150);
    goto_edge(302);
    check_val("load_tick", 16'h0149);

    async_reset();

    // ZERO blink phases
    goto_edge(49);
    check_disp("zero_on", 4'b1011, 7'b1000000);
    goto_edge(50);
    check_disp("zero_blank", 4'b1111, 7'h7F);
    goto_edge(99);
    check_disp("zero_blank_end", 4'b1111, 7'h7F);
    goto_edge(100);
    check_val("zero_stays", 16'h0000);
    check_disp("zero_on_again", 4'b0111, 7'b1000000);

    // 120 + add3 = 300, HIGH steady with rotating anodes
    press(6'b000010);                        // E=101
    check_val("add2", 16'h0120);
    press(6'b000100);                        // E=102
    check_val("add3", 16'h0300);
    check_disp("rot_a3", 4'b1101, 7'b1000000);
    tick(1);
    check_disp("rot_a4", 4'b1110, 7'b1000000);
    tick(1);
    check_disp("rot_a1", 4'b0111, 7'b1000000);
    tick(1);
    check_disp("rot_a2", 4'b1011, 7'b0110000);

    // add coinciding with decrement: decrement dropped
    goto_edge(199);
    check_val("high_pre", 16'h0300);
    press(6'b000001);                        // E=200
    check_val("add_vs_dec", 16'h0360);
    goto_edge(300);
    check_val("after_dec", 16'h0359);
    press(6'b001111);                        // E=301 all adds: +660
    check_val("sum_adds", 16'h1019);

    // rst1 mid-countdown
    press(6'b100000);                        // E=302
    check_val("rst1_load", 16'h0015);
    goto_edge(401);
    check_val("rst1_pre", 16'h0015);
    goto_edge(402);
    check_val("rst1_tick", 16'h0014);
    check_disp("low_even", 4'b1101, 7'b1111001);
    goto_edge(502);
    check_val("low_13", 16'h0013);
    check_disp("low_odd", 4'b1111, 7'h7F);
    goto_edge(1801);
    check_val("last_sec", 16'h0001);
    goto_edge(1802);
    check_val("expired", 16'h0000);
    check_disp("expired_on", 4'b1101, 7'b1000000);

    // 180 boundary
    press(6'b000100);                        // E=1803
    check_val("b180", 16'h0180);
    check_disp("b180_on", 4'b1110, 7'b1000000);
    goto_edge(1901);
    check_disp("b180_steady", 4'b1011, 7'b1111001);
    goto_edge(1902);
    check_val("b179", 16'h0179);
    check_disp("b179_blank", 4'b1111, 7'h7F);

    async_reset();

    // held button gives one event; then saturation
    set_btn(6'b000001);
    tick(5);
    set_btn(6'b0);
    check_val("hold_once", 16'h0060);
    for (int k = 0; k < 37; k++) begin
      set_btn(6'b001000);
      tick(1);
      set_btn(6'b0);
      tick(1);
    end
    check_val("saturate", 16'h9999);
    goto_edge(99);
    check_val("sat_pre", 16'h9999);
    goto_edge(100);
    check_val("sat_tick", 16'h9998);
    goto_edge(200);
    check_val("sat_tick2", 16'h9997);
    check_disp("sat_disp", 4'b0111, 7'b0010000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
